// File: rtl/board_ctrl.sv
// Memory-game board controller: 6x6 cursor, two-card select, typed compare via external memory.
// Define BOARD_CTRL_WRAP_EN to make cursor moves wrap at the board edges instead of saturating.
module board_ctrl #(
  parameter int TYPE_W = 4
) (
  input  logic              clk100_in,
  input  logic              rst_n_in,
  input  logic              new_game,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_sel,
  output logic [5:0]        type_addr,
  input  logic [TYPE_W-1:0] type_data,
  output logic [35:0]       hidden_bus,
  output logic [35:0]       blink_bus,
  output logic [35:0]       sel_bus,
  output logic              match_pulse,
  output logic              mismatch_pulse,
  output logic              busy,
  output logic              board_clear
);

`ifdef BOARD_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ONE, RD_A, RD_B, CMP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        row_q, row_d, col_q, col_d;
  logic [5:0]        first_q, first_d, second_q, second_d;
  logic [TYPE_W-1:0] type_a_q, type_a_d;
  logic [35:0]       hidden_q, hidden_d, sel_q, sel_d, blink_q, blink_d;
  logic              match_q, match_d, mismatch_q, mismatch_d, clear_q, clear_d;
  logic [5:0]        cur_idx, next_idx;

  assign cur_idx  = ({3'b000, row_q} * 6'd6) + {3'b000, col_q};
  assign next_idx = ({3'b000, row_d} * 6'd6) + {3'b000, col_d};

  // Cursor: one move per cycle, up > down > left > right, accepted in every state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    row_d = row_q;
    col_d = col_q;
    if (btn_up) begin
      if (row_q != 3'd0)  row_d = row_q - 3'd1;
      else if (WRAP)      row_d = 3'd5;
    end else if (btn_down) begin
      if (row_q != 3'd5)  row_d = row_q + 3'd1;
      else if (WRAP)      row_d = 3'd0;
    end else if (btn_left) begin
      if (col_q != 3'd0)  col_d = col_q - 3'd1;
      else if (WRAP)      col_d = 3'd5;
    end else if (btn_right) begin
      if (col_q != 3'd5)  col_d = col_q + 3'd1;
      else if (WRAP)      col_d = 3'd0;
    end
    if (new_game) begin
      row_d = 3'd0;
      col_d = 3'd0;
    end
    blink_d = 36'd1 << next_idx;
  end

  // Selection FSM; btn_sel always acts on the pre-move cursor (cur_idx).
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    second_d   = second_q;
    type_a_d   = type_a_q;
    hidden_d   = hidden_q;
    sel_d      = sel_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_sel && !hidden_q[cur_idx]) begin
          sel_d[cur_idx] = 1'b1;
          first_d        = cur_idx;
          state_d        = ONE;
        end
      end
      ONE: begin
        if (btn_sel) begin
          if (cur_idx == first_q) begin
            sel_d[cur_idx] = 1'b0;
            state_d        = IDLE;
          end else if (!hidden_q[cur_idx]) begin
            sel_d[cur_idx] = 1'b1;
            second_d       = cur_idx;
            state_d        = RD_A;
          end
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        type_a_d = type_data;
        state_d  = CMP;
      end
      CMP: begin
        sel_d[first_q]  = 1'b0;
        sel_d[second_q] = 1'b0;
        if (type_data == type_a_q) begin
          hidden_d[first_q]  = 1'b1;
          hidden_d[second_q] = 1'b1;
          match_d            = 1'b1;
        end else begin
          mismatch_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new game discards whatever compare was in flight.
    if (new_game) begin
      state_d    = IDLE;
      hidden_d   = '0;
      sel_d      = '0;
      match_d    = 1'b0;
      mismatch_d = 1'b0;
    end
    clear_d = &hidden_d;
  end

  always_ff @(posedge clk100_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      first_q    <= 6'd0;
      second_q   <= 6'd0;
      type_a_q   <= '0;
      hidden_q   <= '0;
      sel_q      <= '0;
      blink_q    <= 36'h1;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      first_q    <= first_d;
      second_q   <= second_d;
      type_a_q   <= type_a_d;
      hidden_q   <= hidden_d;
      sel_q      <= sel_d;
      blink_q    <= blink_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      clear_q    <= clear_d;
    end
  end

  // Memory is read one cycle ahead: RD_A fetches type A, RD_B fetches type B.
  always_comb begin
    unique case (state_q)
      RD_A:      type_addr = first_q;
      RD_B, CMP: type_addr = second_q;
      default:   type_addr = cur_idx;
    endcase
  end

  assign busy           = (state_q == RD_A) || (state_q == RD_B) || (state_q == CMP);
  assign hidden_bus     = hidden_q;
  assign blink_bus      = blink_q;
  assign sel_bus        = sel_q;
  assign match_pulse    = match_q;
  assign mismatch_pulse = mismatch_q;
  assign board_clear    = clear_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl: directed scenarios plus randomized play against a card-level model.
module tb_board_ctrl;
  localparam int TYPE_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              new_game = 1'b0;
  logic              up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, sel = 1'b0;
  logic [5:0]        type_addr;
  logic [TYPE_W-1:0] type_data;
  logic [35:0]       hidden, blink, selb;
  logic              match, mismatch, busy, board_clear;

  logic [TYPE_W-1:0] type_mem [36];
  int checks = 0;
  int failures = 0;

  // Model state: cursor, card flags, cards picked so far, cycles left until the verdict.
  int          m_row, m_col, m_picks, m_wait, m_first, m_second;
  logic [35:0] m_hidden, m_sel;
  bit          m_match, m_mismatch;

  board_ctrl #(.TYPE_W(TYPE_W)) dut (
    .clk100_in(clk), .rst_n_in(rst_n), .new_game(new_game),
    .btn_up(up), .btn_down(down), .btn_left(left), .btn_right(right), .btn_sel(sel),
    .type_addr(type_addr), .type_data(type_data),
    .hidden_bus(hidden), .blink_bus(blink), .sel_bus(selb),
    .match_pulse(match), .mismatch_pulse(mismatch), .busy(busy), .board_clear(board_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) type_data <= type_mem[type_addr];

  function automatic int bump(input int v, input int dlt);
    int nv;
    nv = v + dlt;
    if (nv < 0 || nv > 5) begin
`ifdef BOARD_CTRL_WRAP_EN
      return (nv + 6) % 6;
`else
      return v;
`endif
    end
    return nv;
  endfunction

  function automatic void model_reset();
    m_row = 0; m_col = 0; m_picks = 0; m_wait = 0; m_first = 0; m_second = 0;
    m_hidden = '0; m_sel = '0; m_match = 0; m_mismatch = 0;
  endfunction

  function automatic void model_step(input bit u, d, l, r, s, ng);
    int idx;
    m_match = 0;
    m_mismatch = 0;
    if (ng) begin
      model_reset();
      return;
    end
    idx = m_row * 6 + m_col;
    if (m_picks == 2) begin
      if (m_wait > 1) m_wait--;
      else begin
        m_sel[m_first] = 1'b0;
        m_sel[m_second] = 1'b0;
        if (type_mem[m_first] == type_mem[m_second]) begin
          m_hidden[m_first] = 1'b1;
          m_hidden[m_second] = 1'b1;
          m_match = 1;
        end else m_mismatch = 1;
        m_picks = 0;
      end
    end else if (s && !m_hidden[idx]) begin
      if (m_picks == 0) begin
        m_sel[idx] = 1'b1; m_first = idx; m_picks = 1;
      end else if (idx == m_first) begin
        m_sel[idx] = 1'b0; m_picks = 0;
      end else begin
        m_sel[idx] = 1'b1; m_second = idx; m_picks = 2; m_wait = 3;
      end
    end
    if (u)      m_row = bump(m_row, -1);
    else if (d) m_row = bump(m_row, 1);
    else if (l) m_col = bump(m_col, -1);
    else if (r) m_col = bump(m_col, 1);
  endfunction

  // Drive one clock of inputs (from a negedge), advance the model, return at the next negedge.
  task automatic cycle(input bit u, d, l, r, s, ng);
    up = u; down = d; left = l; right = r; sel = s; new_game = ng;
    model_step(u, d, l, r, s, ng);
    @(posedge clk);
    @(negedge clk);
    up = 0; down = 0; left = 0; right = 0; sel = 0; new_game = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic goto(input int target);
    int r, c;
    r = target / 6;
    c = target % 6;
    while (m_row < r) cycle(0, 1, 0, 0, 0, 0);
    while (m_row > r) cycle(1, 0, 0, 0, 0, 0);
    while (m_col < c) cycle(0, 0, 0, 1, 0, 0);
    while (m_col > c) cycle(0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 36; i++) type_mem[i] = TYPE_W'(i % 16);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (blink !== 36'h1) begin failures++; $display("FAIL reset_blink got=%h exp=%h", blink, 36'h1); end
    checks++; if (hidden !== 36'h0 || selb !== 36'h0) begin failures++; $display("FAIL reset_bus hidden=%h sel=%h exp=0", hidden, selb); end
    checks++; if ({match, mismatch, busy, board_clear} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {match, mismatch, busy, board_clear}); end
    checks++; if (type_addr !== 6'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", type_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cursor_walk();
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    checks++; if (blink !== 36'h200) begin failures++; $display("FAIL walk_blink got=%h exp=%h", blink, 36'h200); end
    checks++; if (type_addr !== 6'd9) begin failures++; $display("FAIL walk_addr got=%0d exp=9", type_addr); end
  endtask

  task automatic test_match();
    cycle(0, 0, 0, 0, 0, 1);
    type_mem[0] = 3; type_mem[7] = 3;
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (selb !== 36'h1) begin failures++; $display("FAIL match_sel1 got=%h exp=%h", selb, 36'h1); end
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (selb !== 36'h81 || busy !== 1'b1) begin failures++; $display("FAIL match_sel2 sel=%h busy=%b exp sel=%h busy=1", selb, busy, 36'h81); end
    idle(2);
    checks++; if (match !== 1'b0 || hidden !== 36'h0 || busy !== 1'b1) begin failures++; $display("FAIL match_early match=%b hidden=%h busy=%b exp 0/0/1", match, hidden, busy); end
    idle(1);
    checks++; if (hidden !== 36'h81 || selb !== 36'h0) begin failures++; $display("FAIL match_bus hidden=%h sel=%h exp hidden=%h sel=0", hidden, selb, 36'h81); end
    checks++; if ({match, mismatch, busy} !== 3'b100) begin failures++; $display("FAIL match_strobe got=%b exp=100", {match, mismatch, busy}); end
    idle(1);
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL match_width got=%b exp=0", match); end
  endtask

  task automatic test_mismatch();
    cycle(0, 0, 0, 0, 0, 1);
    type_mem[0] = 2; type_mem[1] = 5;
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    idle(3);
    checks++; if ({match, mismatch} !== 2'b01) begin failures++; $display("FAIL mism_strobe got=%b exp=01", {match, mismatch}); end
    checks++; if (selb !== 36'h0 || hidden !== 36'h0) begin failures++; $display("FAIL mism_bus sel=%h hidden=%h exp 0/0", selb, hidden); end
    idle(1);
    checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL mism_width got=%b exp=0", mismatch); end
  endtask

  task automatic test_edge();
    logic [35:0] exp_blink;
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 0);
    checks++; if (blink !== 36'h20) begin failures++; $display("FAIL edge_pre got=%h exp=%h", blink, 36'h20); end
    cycle(0, 0, 0, 1, 0, 0);
`ifdef BOARD_CTRL_WRAP_EN
    exp_blink = 36'h1;
`else
    exp_blink = 36'h20;
`endif
    checks++; if (blink !== exp_blink) begin failures++; $display("FAIL edge_right got=%h exp=%h", blink, exp_blink); end
  endtask

  task automatic test_cancel_ignore();
    cycle(0, 0, 0, 0, 0, 1);
    goto(4);
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (selb !== 36'h10) begin failures++; $display("FAIL cancel_sel1 got=%h exp=%h", selb, 36'h10); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (selb !== 36'h0 || busy !== 1'b0) begin failures++; $display("FAIL cancel_sel2 sel=%h busy=%b exp 0/0", selb, busy); end
    type_mem[10] = 6; type_mem[11] = 6;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    idle(1);
    cycle(1, 0, 1, 0, 1, 0);
    checks++; if (blink !== 36'h20) begin failures++; $display("FAIL prio_blink got=%h exp=%h", blink, 36'h20); end
    idle(1);
    checks++; if (hidden !== 36'hC00 || selb !== 36'h0 || match !== 1'b1) begin failures++; $display("FAIL ignore_res hidden=%h sel=%h match=%b exp %h/0/1", hidden, selb, match, 36'hC00); end
    idle(1);
    checks++; if (selb !== 36'h0 || busy !== 1'b0) begin failures++; $display("FAIL ignore_queue sel=%h busy=%b exp 0/0", selb, busy); end
  endtask

  task automatic test_new_game_abort();
    cycle(0, 0, 0, 0, 0, 1);
    type_mem[0] = 9; type_mem[1] = 9;
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    idle(1);
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (match !== 1'b0 || hidden !== 36'h0 || selb !== 36'h0 || blink !== 36'h1) begin failures++; $display("FAIL ng_abort cyc=%0d match=%b hidden=%h sel=%h blink=%h", i, match, hidden, selb, blink); end
      idle(1);
    end
  endtask

  task automatic test_reset_abort();
    cycle(0, 0, 0, 0, 0, 1);
    type_mem[0] = 4; type_mem[1] = 4;
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    idle(1);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || selb !== 36'h0 || blink !== 36'h1 || type_addr !== 6'd0) begin failures++; $display("FAIL rst_async busy=%b sel=%h blink=%h addr=%0d", busy, selb, blink, type_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++; if (match !== 1'b0 || hidden !== 36'h0) begin failures++; $display("FAIL rst_abort cyc=%0d match=%b hidden=%h exp 0/0", i, match, hidden); end
    end
  endtask

  task automatic test_board_clear();
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 36; i++) type_mem[i] = TYPE_W'(i / 2);
    for (int k = 0; k < 18; k++) begin
      if (k == 17) begin
        checks++; if (board_clear !== 1'b0) begin failures++; $display("FAIL clear_early got=%b exp=0", board_clear); end
      end
      goto(2 * k);
      cycle(0, 0, 0, 0, 1, 0);
      goto(2 * k + 1);
      cycle(0, 0, 0, 0, 1, 0);
      idle(3);
    end
    checks++; if (board_clear !== 1'b1 || hidden !== {36{1'b1}}) begin failures++; $display("FAIL clear_all clear=%b hidden=%h exp 1/all", board_clear, hidden); end
    cycle(0, 0, 0, 0, 0, 1);
    checks++; if (hidden !== 36'h0) begin failures++; $display("FAIL clear_ng_hidden got=%h exp=0", hidden); end
    idle(1);
    checks++; if (board_clear !== 1'b0) begin failures++; $display("FAIL clear_ng_flag got=%b exp=0", board_clear); end
  endtask

  task automatic test_random();
    int idx;
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 36; i++) type_mem[i] = TYPE_W'($urandom_range(0, 3));
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
      idx = m_row * 6 + m_col;
      checks++; if (blink !== (36'd1 << idx)) begin failures++; $display("FAIL rnd_blink n=%0d got=%h exp=%h", n, blink, 36'd1 << idx); end
      checks++; if (hidden !== m_hidden || selb !== m_sel) begin failures++; $display("FAIL rnd_bus n=%0d hidden=%h/%h sel=%h/%h", n, hidden, m_hidden, selb, m_sel); end
      checks++; if ({match, mismatch} !== {m_match, m_mismatch}) begin failures++; $display("FAIL rnd_strobe n=%0d got=%b exp=%b", n, {match, mismatch}, {m_match, m_mismatch}); end
      checks++; if (busy !== (m_picks == 2) || board_clear !== (&m_hidden)) begin failures++; $display("FAIL rnd_flags n=%0d busy=%b clear=%b", n, busy, board_clear); end
      if (m_picks < 2) begin
        checks++; if (type_addr !== 6'(idx)) begin failures++; $display("FAIL rnd_addr n=%0d got=%0d exp=%0d", n, type_addr, idx); end
      end else if (m_wait == 3) begin
        checks++; if (type_addr !== 6'(m_first)) begin failures++; $display("FAIL rnd_addr_a n=%0d got=%0d exp=%0d", n, type_addr, m_first); end
      end else if (m_wait == 2) begin
        checks++; if (type_addr !== 6'(m_second)) begin failures++; $display("FAIL rnd_addr_b n=%0d got=%0d exp=%0d", n, type_addr, m_second); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cursor_walk();
    test_match();
    test_mismatch();
    test_edge();
    test_cancel_ignore();
    test_new_game_abort();
    test_reset_abort();
    test_board_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 Parameter TYPE_W, default 4, card-type width in bits.
REQ-002 clk100_in  input  1  system clock, 100 MHz, all state on rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 new_game  input  1  synchronous board clear, one-cycle pulse.
REQ-005 btn_up / btn_down / btn_left / btn_right / btn_sel  input  1 each  debounced single-cycle pulses.
REQ-006 type_addr  output  6  card-type memory address, index = row*6+col.
REQ-007 type_data  input  TYPE_W  card type, valid one cycle after type_addr.
REQ-008 hidden_bus / blink_bus / sel_bus  output  36 each  per-card display state, registered.
REQ-009 match_pulse / mismatch_pulse  output  1 each  one-cycle result strobes.
REQ-010 busy  output  1  high in states RD_A, RD_B, CMP.
REQ-011 board_clear  output  1  registered; high while all 36 hidden_bus bits are 1.

Function
REQ-012 The cursor SHALL be held as row, col (0..5 each); blink_bus SHALL be one-hot at row*6+col.
REQ-013 Direction priority SHALL be up > down > left > right; only the highest-priority asserted direction applies per cycle.
REQ-014 Up/down SHALL change row by -1/+1, left/right col by -1/+1; edge behaviour per REQ-026.
REQ-015 Moves SHALL be accepted in every FSM state.
REQ-016 The FSM SHALL have states IDLE, ONE, RD_A, RD_B, CMP.
REQ-017 btn_sel SHALL use the cursor value before any same-cycle move.
REQ-018 IDLE: btn_sel on a non-hidden card -> set its sel_bus bit, latch first index, go to ONE; btn_sel on a hidden card ignored.
REQ-019 ONE: btn_sel on the first card -> clear its sel_bus bit, go to IDLE; on a hidden card -> ignored; otherwise -> set sel_bus bit, latch second index, go to RD_A.
REQ-020 RD_A: type_addr = first index. RD_B: type_addr = second index, type_data captured as type A. CMP: type_data captured as type B, compared.
REQ-021 Leaving CMP: clear both sel_bus bits and go to IDLE. If types are equal, set both hidden_bus bits and assert match_pulse next cycle; otherwise assert mismatch_pulse next cycle.
REQ-022 Latency: with the second select accepted at edge E0, hidden_bus/sel_bus update and the strobe asserts at edge E3.
REQ-023 btn_sel in RD_A, RD_B, CMP SHALL be ignored, not queued.
REQ-024 In IDLE and ONE, type_addr SHALL equal the cursor index.
REQ-025 new_game SHALL override all other inputs: hidden_bus, sel_bus and strobes to 0, cursor to (0,0), FSM to IDLE, next edge; a mid-compare result is discarded.

Configuration
REQ-026 BOARD_CTRL_WRAP_EN defined: moves past an edge wrap (col 5 + right -> col 0 same row; row 0 + up -> row 5). Undefined: moves past an edge are ignored and the cursor saturates.

Reset
REQ-027 rst_n_in low SHALL asynchronously force: FSM IDLE; cursor (0,0); blink_bus 36'h1; hidden_bus, sel_bus 0; match_pulse, mismatch_pulse, busy, board_clear 0; type_addr 0.
REQ-028 Reset SHALL abort any compare in progress without updating hidden_bus.

Verification
REQ-029 Reset release, btn_right x3, btn_down x1 -> blink_bus bit 9 only, type_addr 9.
REQ-030 Select 0, then select 7, memory returns type 3 for both -> at E3 hidden_bus bits 0 and 7 set, sel_bus 0, match_pulse for 1 cycle, busy low.
REQ-031 Select 0 (type 2), select 1 (type 5) -> mismatch_pulse 1 cycle, sel_bus 0, hidden_bus unchanged.
REQ-032 Cursor (0,5), btn_right -> with BOARD_CTRL_WRAP_EN cursor (0,0), blink_bus 36'h1; without, cursor (0,5), blink bit 5.
REQ-033 Select 4, select 4 again -> sel_bus 0, FSM IDLE; btn_sel during RD_B and btn_up+btn_left simultaneously -> select ignored, only row decrements.
REQ-034 Match all 18 pairs -> board_clear high; new_game pulse -> hidden_bus 0, board_clear low next cycle.
